// File: rtl/whirlpool_pkg.sv
// whirlpool_pkg: shared widths, FSM state set and default IV for the Whirlpool MP controller.
package whirlpool_pkg;
  localparam int WP_BLK_W = 512;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, OUT} wp_mp_state_t;
  localparam logic [WP_BLK_W-1:0] WP_IV_ZERO = '0;
endpackage

// File: rtl/whirlpool_mp_xor3.sv
// whirlpool_mp_xor3: chaining register holding H, loads IV or a ^ b ^ c.
module whirlpool_mp_xor3
  import whirlpool_pkg::*;
#(
  parameter logic [WP_BLK_W-1:0] IV = WP_IV_ZERO
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_load_iv,
  input  logic                i_upd,
  input  logic [WP_BLK_W-1:0] i_a,
  input  logic [WP_BLK_W-1:0] i_b,
  input  logic [WP_BLK_W-1:0] i_c,
  output logic [WP_BLK_W-1:0] o_q
);
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) o_q <= IV;
    else if (i_load_iv) o_q <= IV;
    else if (i_upd) o_q <= i_a ^ i_b ^ i_c;
endmodule

// File: rtl/whirlpool_mp_ctrl.sv
// whirlpool_mp_ctrl: Miyaguchi-Preneel chaining controller driving the Whirlpool W-cipher core.
// Optional WHIRLPOOL_TIMEOUT_EN adds o_timeout and a WAIT-cycle limit of TIMEOUT_CYC.
module whirlpool_mp_ctrl
  import whirlpool_pkg::*;
#(
  parameter logic [WP_BLK_W-1:0] IV = WP_IV_ZERO,
  parameter int MASK_CYC = 1
`ifdef WHIRLPOOL_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_clr,
  input  logic                i_blk_valid,
  output logic                o_blk_ready,
  input  logic [WP_BLK_W-1:0] i_blk_data,
  input  logic                i_blk_last,
  output logic                o_core_init,
  output logic [WP_BLK_W-1:0] o_core_data,
  output logic [WP_BLK_W-1:0] o_core_key,
  input  logic [WP_BLK_W-1:0] i_core_hash,
  input  logic                i_core_valid,
  output logic                o_dig_valid,
  input  logic                i_dig_ready,
  output logic [WP_BLK_W-1:0] o_digest,
`ifdef WHIRLPOOL_TIMEOUT_EN
  output logic                o_timeout,
`endif
  output logic                o_busy
);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_LAUNCH = LAUNCH;
  localparam logic [1:0] S_WAIT = WAIT;
  localparam logic [1:0] S_OUT = OUT;
  localparam int CW = 16;
  localparam logic [CW-1:0] MASK_W = CW'(MASK_CYC);
  logic [1:0] state, state_nx;
  logic [CW-1:0] cnt;
  logic [WP_BLK_W-1:0] m, h;
  logic last_q, take, dig_take, to_hit;
  assign take = state == S_WAIT && cnt >= MASK_W && i_core_valid;
  assign dig_take = state == S_OUT && i_dig_ready;
`ifdef WHIRLPOOL_TIMEOUT_EN
  localparam logic [CW-1:0] TO_W = CW'(TIMEOUT_CYC);
  assign to_hit = state == S_WAIT && !take && cnt >= TO_W - 1'b1;
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) o_timeout <= 1'b0;
    else if (i_clr) o_timeout <= 1'b0;
    else if (to_hit) o_timeout <= 1'b1;
`else
  assign to_hit = 1'b0;
`endif
  always_comb
    state_nx = i_clr ? S_IDLE :
               state == S_IDLE   ? (i_blk_valid ? S_LAUNCH : S_IDLE) :
               state == S_LAUNCH ? S_WAIT :
               state == S_WAIT   ? (take ? (last_q ? S_OUT : S_IDLE) : (to_hit ? S_IDLE : S_WAIT)) :
               (i_dig_ready ? S_IDLE : S_OUT);
  // wait counter saturates so an indefinitely stalled core never re-enters the mask window
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      state  <= S_IDLE;
      cnt    <= '0;
      m      <= '0;
      last_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= (state == S_WAIT) ? cnt + {{(CW-1){1'b0}}, ~&cnt} : '0;
      if (state == S_IDLE && i_blk_valid && !i_clr) begin
        m      <= i_blk_data;
        last_q <= i_blk_last;
      end
    end
  whirlpool_mp_xor3 #(.IV(IV)) u_h (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_load_iv(i_clr | dig_take | to_hit),
    .i_upd    (take),
    .i_a      (i_core_hash),
    .i_b      (h),
    .i_c      (m),
    .o_q      (h)
  );
  assign o_blk_ready = state == S_IDLE;
  assign o_busy      = state != S_IDLE;
  assign o_core_init = state == S_LAUNCH && !i_clr;
  assign o_core_data = m;
  assign o_core_key  = h;
  assign o_dig_valid = state == S_OUT;
  assign o_digest    = h;
endmodule

// File: tb/tb_whirlpool_mp_ctrl.sv
// tb_whirlpool_mp_ctrl: randomized bench with stub core E(m)=m+1 and a transaction-level model.
module tb_whirlpool_mp_ctrl;
  localparam int MASK = 1;
  localparam int TO = 64;
  logic clk = 0, rstn = 0, clr = 0, blk_valid = 0, blk_last = 0, core_valid = 0, dig_ready = 0;
  logic [511:0] blk_data = '0, core_hash = '0;
  logic blk_ready, core_init, dig_valid, busy;
  logic [511:0] core_data, core_key, digest;
`ifdef WHIRLPOOL_TIMEOUT_EN
  logic timeout;
`endif
  int tests = 0, fails = 0;
  int ph, waited, cd, stale_n, lat = 10, n;
  logic [511:0] mh, mm, pend, saw_data;
  logic mlast, mto, sticky = 0, stub_off = 0, saw_init = 0;

  whirlpool_mp_ctrl dut (
    .i_clk(clk), .i_rstn(rstn), .i_clr(clr), .i_blk_valid(blk_valid), .o_blk_ready(blk_ready),
    .i_blk_data(blk_data), .i_blk_last(blk_last), .o_core_init(core_init), .o_core_data(core_data),
    .o_core_key(core_key), .i_core_hash(core_hash), .i_core_valid(core_valid), .o_dig_valid(dig_valid),
    .i_dig_ready(dig_ready), .o_digest(digest),
`ifdef WHIRLPOOL_TIMEOUT_EN
    .o_timeout(timeout),
`endif
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    ph = 0; mh = '0; mm = '0; mlast = 0; waited = 0; mto = 0;
    cd = 0; stale_n = 0; core_valid = 0; saw_init = 0;
  endtask

  // ph: 0 idle, 1 launch, 2 waiting on core, 3 digest offered
  task automatic model_step();
    if (clr) begin
      mh = '0; ph = 0; mto = 0;
    end else if (ph == 0) begin
      if (blk_valid) begin mm = blk_data; mlast = blk_last; ph = 1; end
    end else if (ph == 1) begin
      waited = 0; ph = 2;
    end else if (ph == 2) begin
      if (waited >= MASK && core_valid) begin
        mh = core_hash ^ mh ^ mm;
        ph = mlast ? 3 : 0;
      end
`ifdef WHIRLPOOL_TIMEOUT_EN
      else if (waited + 1 >= TO) begin
        mto = 1; mh = '0; ph = 0;
      end
`endif
      waited++;
    end else if (dig_ready) begin
      mh = '0; ph = 0;
    end
  endtask

  task automatic stub_step();
    if (saw_init) begin
      cd = lat; pend = saw_data + 512'd1;
      if (sticky) stale_n = 1; else core_valid = 0;
    end else if (stale_n > 0) begin
      stale_n = 0; core_valid = 0;
    end
    if (cd > 0) begin
      cd--;
      if (cd == 0 && !stub_off) begin core_valid = 1; core_hash = pend; end
    end else if (!sticky && core_valid) core_valid = 0;
  endtask

  task automatic compare();
    chk("blk_ready", blk_ready, ph == 0);
    chk("busy", busy, ph != 0);
    chk("core_init", core_init, ph == 1 && !clr);
    chk("dig_valid", dig_valid, ph == 3);
    if (ph == 1 || ph == 2) begin
      chk("core_data", core_data, mm);
      chk("core_key", core_key, mh);
    end
    if (ph == 3) chk("digest", digest, mh);
`ifdef WHIRLPOOL_TIMEOUT_EN
    chk("timeout", timeout, mto);
`endif
    saw_init = core_init;
    saw_data = core_data;
  endtask

  task automatic step();
    @(posedge clk);
    if (rstn) model_step();
    #1;
    if (rstn) stub_step();
    @(negedge clk);
    compare();
  endtask

  task automatic apply_reset();
    rstn = 0;
    model_reset();
    #1;
    compare();
    chk("rst_blk_ready", blk_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_init", core_init, 0);
    chk("rst_dig_valid", dig_valid, 0);
    chk("rst_core_data", core_data, 0);
    chk("rst_core_key", core_key, 0);
  endtask

  task automatic wait_dig(output int cnt);
    cnt = 0;
    while (!dig_valid && cnt < 100) begin step(); cnt++; end
    chk("dig_wait", dig_valid, 1);
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!blk_ready && k < 100) begin step(); k++; end
    chk("ready_wait", blk_ready, 1);
  endtask

  task automatic send(input logic [511:0] d, input logic l);
    blk_valid = 1; blk_data = d; blk_last = l;
    step();
    blk_valid = 0;
  endtask

  task automatic handshake();
    dig_ready = 1;
    step();
    dig_ready = 0;
  endtask

  initial begin
    model_reset();
    #1;
    apply_reset();
    @(negedge clk);
    rstn = 1;

    // single block, latency pinned
    lat = 10;
    send(512'h0, 1);
    wait_dig(n);
    chk("accept_to_dig", 512'(n + 1), 512'd12);
    chk("digest_single", digest, 512'h1);
    handshake();
    chk("ready_after_out", blk_ready, 1);

    // two-block message
    blk_valid = 1; blk_data = 512'h0; blk_last = 0;
    step();
    blk_data = 512'h5; blk_last = 1;
    chk("ready_low_between", blk_ready, 0);
    wait_ready();
    step();
    blk_valid = 0;
    wait_dig(n);
    chk("digest_two", digest, 512'h2);
    handshake();

    // sticky valid from the previous run must be masked
    sticky = 1; lat = 4;
    send(512'h10, 1);
    wait_dig(n);
    chk("digest_a", digest, 512'h1);
    handshake();
    send(512'h3, 1);
    wait_dig(n);
    chk("digest_stale", digest, 512'h7);
    handshake();
    sticky = 0;

    // consumer stall in OUT
    lat = 3;
    send(512'h9, 1);
    wait_dig(n);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("hold_valid", dig_valid, 1);
      chk("hold_digest", digest, 512'h3);
    end
    blk_valid = 1; blk_data = 512'h20; blk_last = 1;
    handshake();
    chk("ready_after_release", blk_ready, 1);
    step();
    blk_valid = 0;
    chk("relaunch_init", core_init, 1);
    chk("relaunch_key_iv", core_key, 512'h0);
    chk("relaunch_data", core_data, 512'h20);
    wait_dig(n);
    chk("digest_relaunch", digest, 512'h1);
    handshake();

    // clear in the same cycle as the core result
    lat = 5;
    send(512'h0, 0);
    wait_ready();
    send(512'h7, 1);
    n = 0;
    while (!core_valid && n < 100) begin step(); n++; end
    chk("valid_seen", core_valid, 1);
    clr = 1;
    step();
    clr = 0;
    chk("clr_busy", busy, 0);
    chk("clr_h_iv", digest, 512'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("clr_no_dig", dig_valid, 0);
    end

    // asynchronous reset while waiting
    lat = 8;
    send(512'h44, 1);
    repeat (3) step();
    apply_reset();
    step();
    rstn = 1;
    step();
    chk("post_rst_ready", blk_ready, 1);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      blk_valid = $urandom % 2 == 0;
      blk_data = ($urandom % 4 == 0) ? {16{$urandom()}} : 512'($urandom % 16);
      blk_last = $urandom % 3 == 0;
      dig_ready = $urandom % 2 == 0;
      clr = $urandom % 50 == 0;
      lat = $urandom_range(2, 12);
      sticky = $urandom % 2 == 0;
      if ($urandom % 400 == 0) begin
        apply_reset();
        step();
        rstn = 1;
      end
      step();
    end
    blk_valid = 0; clr = 0; dig_ready = 0; sticky = 0;
    clr = 1;
    step();
    clr = 0;

`ifdef WHIRLPOOL_TIMEOUT_EN
    stub_off = 1;
    send(512'h1, 1);
    n = 0;
    while (!timeout && n < 200) begin step(); n++; end
    chk("timeout_cycles", 512'(n), 512'd65);
    chk("timeout_idle", busy, 0);
    step();
    chk("timeout_sticky", timeout, 1);
    clr = 1;
    step();
    clr = 0;
    chk("timeout_cleared", timeout, 0);
    stub_off = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/whirlpool_mp_ctrl.md
Name: whirlpool_mp_ctrl

Overview:
- Miyaguchi-Preneel chaining controller that acts as the initiator for the iterative Whirlpool W-cipher core.
- Accepts pre-padded 512-bit message blocks over a valid/ready stream.
- Per block: launches the core with data = block and key = chaining value H, waits for the core result, then updates H <= E_H(m) ^ H ^ m.
- After the last block, presents H as the digest on an output valid/ready port. Sits between the PBKDF2/HMAC sequencer (upstream) and the cipher core (downstream).

Parameters:
- IV, 512'h0, chaining value loaded at reset, at o_dig handshake and on i_clr.
- MASK_CYC, 1, number of WAIT cycles after launch in which i_core_valid is ignored (covers a sticky valid from the previous run).
- TIMEOUT_CYC, 64, WAIT-cycle limit; used only with WHIRLPOOL_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous, active-low reset
- i_clr  in  1  synchronous abort: H <= IV, state <= IDLE
- i_blk_valid  in  1  block valid
- o_blk_ready  out  1  controller can take a block
- i_blk_data  in  512  padded message block
- i_blk_last  in  1  final block of the message
- o_core_init  out  1  one-cycle launch pulse to the cipher core
- o_core_data  out  512  plaintext to the core (registered m)
- o_core_key  out  512  key to the core (registered H)
- i_core_hash  in  512  cipher output E_H(m)
- i_core_valid  in  1  cipher output valid
- o_dig_valid  out  1  digest valid
- i_dig_ready  in  1  digest consumer ready
- o_digest  out  512  final chaining value
- o_busy  out  1  state != IDLE

Behaviour:
- Reset values: state = IDLE, H = IV, m = 0, o_core_init = 0, o_dig_valid = 0, o_blk_ready = 1, o_busy = 0, counters = 0.
- States: IDLE, LAUNCH, WAIT, OUT.
- IDLE: o_blk_ready = 1.
  - On i_blk_valid: m <= i_blk_data, last_q <= i_blk_last, go to LAUNCH.
- LAUNCH: o_core_init = 1 for exactly this one cycle; wait counter cleared; go to WAIT.
- WAIT: counter increments each cycle.
  - i_core_valid is ignored while counter < MASK_CYC.
  - Otherwise, on i_core_valid: H <= i_core_hash ^ H ^ m. If last_q, go to OUT; else go to IDLE.
- OUT: o_dig_valid = 1 and o_digest = H, both held stable until i_dig_ready.
  - On the handshake: H <= IV, go to IDLE.
- o_core_data and o_core_key are driven from registers and stay stable from LAUNCH until the WAIT exit.
- Latency:
  - Block accept to o_core_init: 1 cycle.
  - Core valid to H update: same edge.
  - H update to o_dig_valid: 1 cycle.
  - OUT handshake to o_blk_ready: 1 cycle.
- Block throughput is bounded by the core latency; there is no input buffering.
- Simultaneous events:
  - i_clr has priority over every transition, including an OUT handshake and a valid arriving in WAIT. o_core_init is suppressed in that cycle.
  - A core result that arrives after an abort is ignored, because the controller is not in WAIT.
- Reset mid-operation returns all registers to their reset values immediately (asynchronous).
- XOR is bitwise on 512 bits; no arithmetic carries.

Optional Feature:
- WHIRLPOOL_TIMEOUT_EN defined:
  - Adds an output o_timeout (1 bit, reset 0).
  - If WAIT exceeds TIMEOUT_CYC cycles without an accepted valid: o_timeout <= 1 (sticky until i_clr or reset), H <= IV, go to IDLE.
- Undefined: no port, no counter compare; WAIT waits indefinitely.

Decomposition:
- Shared package whirlpool_pkg holds:
  - WP_BLK_W = 512.
  - State enum wp_mp_state_t {IDLE, LAUNCH, WAIT, OUT}.
  - Default IV constant WP_IV_ZERO.
- One natural sub-module: whirlpool_mp_xor3, a registered 3-input 512-bit XOR with load/clear for the chaining register.

Test Plan:
- Stub core with E(m) = m + 1 (key ignored) and a valid latency of 10 cycles. Single block m = 0, last = 1 -> o_digest = 512'h1; o_dig_valid asserts 12 cycles after accept.
- Same stub, two blocks m0 = 0 then m1 = 512'h5 with last on m1 -> H1 = 1, final digest = 6 ^ 1 ^ 5 = 512'h2; o_blk_ready is low between the two accepts.
- Stub core holds i_core_valid high from the previous run, MASK_CYC = 1 -> the stale valid is ignored in the first WAIT cycle and the result is taken only on the new valid.
- i_dig_ready held low for 20 cycles in OUT -> o_digest and o_dig_valid stay stable; release -> the next block is accepted 1 cycle later with H = IV.
- i_clr asserted in the same cycle as i_core_valid in WAIT -> H stays IV, state = IDLE, no o_dig_valid; i_rstn pulse during WAIT -> all outputs return to reset values.
- Real Whirlpool core, padded empty-string block -> digest 19FA61D75522A4669B44E39C1D2E1726C530232130D407F89AFEE0964997F7A73E83BE698B288FEBCF88E3E03C4F0757EA8964E59B63D93708B138CC42A66EB3. With WHIRLPOOL_TIMEOUT_EN and the core valid stuck low -> o_timeout = 1 after 64 WAIT cycles.
